// File: rtl/filter_capture.sv
// filter_capture: records DEPTH low/high filter result pairs, then replays them as a valid/ready word stream.
// Optional macro FILTER_CAPTURE_CONTINUOUS_EN: the end of a drain re-arms capture instead of returning to idle.
module filter_capture #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] low_pass,
    input  logic [WIDTH-1:0] high_pass,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    output logic             out_last,
    output logic             busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               phase_q, phase_d;
    logic               wr_en_s;
    logic               hs_s;
    logic [2*WIDTH-1:0] rd_word_s;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_sel_q, out_sel_d;
    logic               out_last_q, out_last_d;
    logic               busy_q, busy_d;

    logic [2*WIDTH-1:0] mem_q [DEPTH];

    assign hs_s = out_valid_q & out_ready;

    // State, pointer and registered-output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            phase_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_sel_q   <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            phase_q     <= phase_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    // Capture storage write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= {high_pass, low_pass};
        end
    end

    // Next-state and pointer logic.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        phase_d  = phase_q;
        wr_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CAPTURE;
                    wr_ptr_d = PTR_ZERO;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (in_valid) begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (wr_ptr_q == PTR_LAST) begin
                        state_d  = ST_DRAIN;
                        rd_ptr_d = PTR_ZERO;
                        phase_d  = 1'b0;
                    end else begin
                        state_d  = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                if (hs_s) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d  = 1'b0;
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        if (rd_ptr_q == PTR_LAST) begin
`ifdef FILTER_CAPTURE_CONTINUOUS_EN
                            state_d  = ST_CAPTURE;
                            wr_ptr_d = PTR_ZERO;
`else
                            state_d  = ST_IDLE;
`endif
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wr_ptr_d = PTR_ZERO;
                rd_ptr_d = PTR_ZERO;
                phase_d  = 1'b0;
            end
        endcase
    end

    // Output values for the next cycle; the word is looked up from the next read position
    // so the first low word is already valid in the cycle DRAIN is entered.
    always_comb begin
        rd_word_s   = mem_q[rd_ptr_d];
        out_valid_d = 1'b0;
        out_data_d  = {WIDTH{1'b0}};
        out_sel_d   = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        if (state_d == ST_DRAIN) begin
            out_valid_d = 1'b1;
            out_sel_d   = phase_d;
            out_last_d  = phase_d & (rd_ptr_d == PTR_LAST);
            if (phase_d) begin
                out_data_d = rd_word_s[2*WIDTH-1:WIDTH];
            end else begin
                out_data_d = rd_word_s[WIDTH-1:0];
            end
        end else begin
            out_valid_d = 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_filter_capture.sv
// Directed bench for filter_capture with DEPTH=4: capture/drain order, stalls, ignored starts, async reset.
module tb_filter_capture;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] low_pass;
    logic [WIDTH-1:0] high_pass;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_last;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;
    int exp_lo [DEPTH];
    int exp_hi [DEPTH];

    filter_capture #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .low_pass  (low_pass),
        .high_pass (high_pass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_busy"},  32'(busy),      32'd0);
        check_eq({tag, "_sel"},   32'(out_sel),   32'd0);
        check_eq({tag, "_last"},  32'(out_last),  32'd0);
        check_eq({tag, "_data"},  out_data,       32'd0);
    endtask

    // Feed DEPTH consecutive valid pairs lo0+k / hi0+k; DRAIN must start right after the last one.
    task automatic capture(input int lo0, input int hi0);
        for (int k = 0; k < DEPTH; k++) begin
            low_pass  = 32'(lo0 + k);
            high_pass = 32'(hi0 + k);
            in_valid  = 1'b1;
            exp_lo[k] = lo0 + k;
            exp_hi[k] = hi0 + k;
            tick();
            check_eq("cap_valid", 32'(out_valid), (k == DEPTH - 1) ? 32'd1 : 32'd0);
            check_eq("cap_busy",  32'(busy), 32'd1);
        end
        in_valid = 1'b0;
    endtask

    // Drain 2*DEPTH words against exp_lo/exp_hi, optionally with random back-pressure.
    task automatic drain_window(input bit rnd_ready, input bit start_on_last);
        int   idx   = 0;
        int   cyc   = 0;
        int   stall = 0;
        int   e;
        logic rdy;
        while (idx < 2 * DEPTH && cyc < 200) begin
            if (rnd_ready) begin
                if (idx == 2 && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end else begin
                    rdy = 1'($urandom_range(0, 1));
                end
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            start     = start_on_last && rdy && (idx == 2 * DEPTH - 1);
            e = idx / 2;
            check_eq("drn_valid", 32'(out_valid), 32'd1);
            check_eq("drn_busy",  32'(busy), 32'd1);
            check_eq("drn_data",  out_data, (idx % 2 == 1) ? 32'(exp_hi[e]) : 32'(exp_lo[e]));
            check_eq("drn_sel",   32'(out_sel), 32'(idx % 2));
            check_eq("drn_last",  32'(out_last), (idx == 2 * DEPTH - 1) ? 32'd1 : 32'd0);
            tick();
            cyc++;
            if (rdy) idx++;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        if (idx < 2 * DEPTH) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d words expected %0d", idx, 2 * DEPTH);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_busy",  32'(busy), 32'd1);
        check_eq("start_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        low_pass  = '0;
        high_pass = '0;
        out_ready = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        in_valid = 1'b1;
        repeat (2) tick();
        check_idle_outputs("rst_held");
        rst = 1'b1;
        tick();
        check_idle_outputs("rst_rel");
        in_valid = 1'b0;

`ifdef FILTER_CAPTURE_CONTINUOUS_EN
        pulse_start();
        capture(0, 100);
        drain_window(1'b0, 1'b0);
        check_eq("cont_gap_valid", 32'(out_valid), 32'd0);
        check_eq("cont_gap_busy",  32'(busy), 32'd1);
        capture(4, 104);
        drain_window(1'b0, 1'b0);
        check_eq("cont_end_valid", 32'(out_valid), 32'd0);
        check_eq("cont_end_busy",  32'(busy), 32'd1);
`else
        // Basic window, ready always high.
        pulse_start();
        capture(0, 100);
        drain_window(1'b0, 1'b0);
        check_eq("t1_post_valid", 32'(out_valid), 32'd0);
        check_eq("t1_post_busy",  32'(busy), 32'd0);

        // Sparse in_valid, start pulsed mid-capture and on the final handshake.
        pulse_start();
        for (int c = 0; c < 10; c++) begin
            low_pass  = 32'(10 + c);
            high_pass = 32'(200 + c);
            in_valid  = (c % 3 == 0);
            start     = (c == 4);
            tick();
            check_eq("t2_valid", 32'(out_valid), (c == 9) ? 32'd1 : 32'd0);
            check_eq("t2_busy",  32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            exp_lo[k] = 10 + 3 * k;
            exp_hi[k] = 200 + 3 * k;
        end
        drain_window(1'b0, 1'b1);
        check_eq("t4_post_valid", 32'(out_valid), 32'd0);
        check_eq("t4_post_busy",  32'(busy), 32'd0);
        tick();
        check_eq("t4_idle_busy",  32'(busy), 32'd0);

        // Back-pressure with a long stall on word 2.
        pulse_start();
        capture(0, 100);
        drain_window(1'b1, 1'b0);
        check_eq("t3_post_valid", 32'(out_valid), 32'd0);
        check_eq("t3_post_busy",  32'(busy), 32'd0);

        // Async reset in the middle of a drain, then a fresh window.
        pulse_start();
        capture(50, 150);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        check_eq("t5_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_idle_outputs("t5_async");
        #2;
        rst = 1'b1;
        tick();
        check_idle_outputs("t5_rel");
        pulse_start();
        capture(7, 77);
        drain_window(1'b0, 1'b0);
        check_eq("t5_post_valid", 32'(out_valid), 32'd0);
        check_eq("t5_post_busy",  32'(busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/filter_capture.md
# filter_capture

Capture-and-drain buffer at the output end of the sample path. It records a fixed-length window of `low_pass`/`high_pass` result pairs from the two IIR filter instances, then plays them back one word at a time over a valid/ready stream. It is the write/readout counterpart of the ROM-addressing sample source: that side feeds samples into the filters, and this block collects the filtered results.

## Interface
Parameters:
- `DEPTH`, 16: pairs captured per window; power of two, ≥2.
- `WIDTH`, 32: sample width, matching the filter outputs.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset (asserts immediately, releases on clk).
- `start`  in  1  one-cycle request to begin a capture window.
- `in_valid`  in  1  current `low_pass`/`high_pass` pair is a new result.
- `low_pass`  in  WIDTH  low-pass filter result.
- `high_pass`  in  WIDTH  high-pass filter result.
- `out_valid`  out  1  `out_data` holds a buffered word.
- `out_ready`  in  1  downstream accepts the word this cycle.
- `out_data`  out  WIDTH  buffered word.
- `out_sel`  out  1  0 = low-pass word, 1 = high-pass word.
- `out_last`  out  1  final word of the window.
- `busy`  out  1  high in CAPTURE or DRAIN.

## Operation
- The buffer holds DEPTH entries of 2×WIDTH. The write pointer and read pointer are each log2(DEPTH) bits. A read-phase bit selects low or high.
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - `start`=1 → CAPTURE; `wr_ptr`←0.
  - `in_valid` is ignored.
- CAPTURE:
  - Each cycle with `in_valid`=1 writes {high_pass, low_pass} at `wr_ptr` and increments `wr_ptr`.
  - The write at `wr_ptr`=DEPTH−1 → DRAIN, with `rd_ptr`←0 and phase←0.
- DRAIN:
  - Presents the entry at `rd_ptr`: low word with `out_sel`=0, then high word with `out_sel`=1.
  - The word advances only on a handshake (`out_valid` && `out_ready`).
  - Handshake on the high word increments `rd_ptr`.
  - `out_last`=1 only on the high word of entry DEPTH−1.
  - Handshake on the last word → IDLE (see Configuration).
- `start` outside IDLE is ignored; it is not queued.
- `in_valid` outside CAPTURE is dropped.
- `busy` = (state ≠ IDLE).
- `out_valid`=1 exactly when in DRAIN.
- While `out_valid`=1 && `out_ready`=0, `out_data`, `out_sel` and `out_last` stay stable.
- Samples are stored and returned bit-exact; there is no arithmetic on data.

## Timing
- Reset values:
  - state = IDLE; `wr_ptr` = `rd_ptr` = phase = 0.
  - `out_valid` = `out_sel` = `out_last` = `busy` = 0; `out_data` = 0.
  - Buffer contents are not reset.
- `start` sampled high at edge N → `busy`=1 after edge N. The first pair accepted is the one with `in_valid` at edge N+1.
- Last capture write at edge M → `out_valid`=1 after edge M. `out_data` = low word of entry 0, registered and valid in that same cycle. No bubble.
- With `out_ready` held at 1, one word transfers per cycle. A full drain takes 2×DEPTH cycles. After the final handshake edge, `out_valid`=0 in the next cycle.
- Per-word order:
  - entry order 0..DEPTH−1;
  - within an entry, low then high.
- Reset asserted mid-CAPTURE or mid-DRAIN: outputs go to their reset values immediately. A partial window is discarded, and no `out_last` is issued.
- `start` in the same cycle as the final drain handshake is ignored, because the state is still DRAIN.

## Configuration
- `FILTER_CAPTURE_CONTINUOUS_EN`:
  - Defined: the final drain handshake goes DRAIN→CAPTURE directly with `wr_ptr`←0. `busy` stays 1, and windows repeat without `start`. `start` is still required to leave IDLE after reset.
  - Undefined: the final drain handshake goes DRAIN→IDLE, and each window needs its own `start` pulse.

## Test plan
- Reset with DEPTH=4 → all outputs 0. Then `start` with `in_valid`=1 constantly, low=k and high=100+k for k=0.. → captured low 0..3 and high 100..103. Drain with `out_ready`=1 yields 0,100,1,101,2,102,3,103 with `out_sel` alternating 0,1. `out_last` is high only on 103. `busy` falls the cycle after.
- `in_valid` pattern 1,0,0,1,… during CAPTURE → only valid cycles are stored, and DRAIN begins after the 4th valid pair.
- `out_ready` toggling randomly, including low for 5 cycles on word 2 → `out_data`, `out_sel` and `out_last` are held stable; the sequence is identical to the first test; no word is duplicated or lost.
- `start` pulsed during CAPTURE and again on the final drain handshake → ignored. The block returns to IDLE (macro undefined), and a new `start` captures a fresh window.
- Async reset asserted mid-DRAIN without a clock edge → `out_valid` and `busy` are 0 immediately. After release, a `start` captures and drains normally.
- With `FILTER_CAPTURE_CONTINUOUS_EN` defined, one `start` → two consecutive windows (values 0..3 then 4..7) drained with no further `start`. `busy` is never low between the windows.
